// File: rtl/nn_parameters_pkg.sv
// Shared constants and types for the classifier back end.
package nn_parameters;

  // Dense layer 3 geometry and score format.
  localparam int unsigned OUT_SIZE_3  = 32;
  localparam int unsigned SCORE_W_3   = 64;
  localparam int unsigned CLASS_IDX_W = $clog2(OUT_SIZE_3);

  typedef logic signed [SCORE_W_3-1:0] score_t;
  typedef logic [CLASS_IDX_W-1:0]      class_idx_t;

  // Default minimum winning score for the optional no-match flag.
  localparam score_t CLASS_THRESHOLD = '0;

  // Argmax sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

endpackage

// File: rtl/class_argmax.sv
// Sequential argmax over the dense layer 3 scores.
// Snapshots the score vector on an accepted input, compares one score per
// cycle and presents the winning index/score through a valid/ready handshake.
// Optional macro SCORE_THRESHOLD_EN: drives no_match when the winning score is
// below THRESHOLD; without it no_match is tied low.
module class_argmax
  import nn_parameters::*;
#(
  parameter int unsigned NUM_CLASSES = OUT_SIZE_3,
  parameter int unsigned SCORE_W     = SCORE_W_3,
  parameter int unsigned IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter logic signed [SCORE_W-1:0] THRESHOLD = SCORE_W'(CLASS_THRESHOLD)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CLASSES-1:0][SCORE_W-1:0]  score_vector,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [IDX_W-1:0]                     class_idx,
  output logic [SCORE_W-1:0]                   max_score,
  output logic                                 no_match,
  output logic                                 result_valid,
  input  logic                                 result_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  // Elaboration-time parameter sanity checks.
  if (NUM_CLASSES < 1) begin : g_bad_num_classes
    $error("class_argmax: NUM_CLASSES must be >= 1");
  end
  if ($bits(THRESHOLD) != SCORE_W) begin : g_bad_threshold_w
    $error("class_argmax: THRESHOLD width must equal SCORE_W");
  end

  argmax_state_e                        state_q, state_d;
  logic [NUM_CLASSES-1:0][SCORE_W-1:0]  snap_q, snap_d;
  logic signed [SCORE_W-1:0]            run_max_q, run_max_d;
  logic [IDX_W-1:0]                     run_idx_q, run_idx_d;
  logic [IDX_W-1:0]                     cnt_q, cnt_d;
  logic signed [SCORE_W-1:0]            cand_max;
  logic [IDX_W-1:0]                     cand_idx;
  logic                                 load;
  logic [IDX_W-1:0]                     load_idx;
  logic signed [SCORE_W-1:0]            load_score;
  logic                                 result_valid_d;
  logic                                 in_ready_d;

  // Next state, scan datapath and result load decisions.
  always_comb begin
    state_d        = state_q;
    snap_d         = snap_q;
    run_max_d      = run_max_q;
    run_idx_d      = run_idx_q;
    cnt_d          = cnt_q;
    load           = 1'b0;
    load_idx       = run_idx_q;
    load_score     = run_max_q;
    result_valid_d = result_valid;
    cand_max       = run_max_q;
    cand_idx       = run_idx_q;

    // Strict signed compare keeps the lowest index on ties.
    if ($signed(snap_q[cnt_q]) > run_max_q) begin
      cand_max = $signed(snap_q[cnt_q]);
      cand_idx = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          snap_d    = score_vector;
          run_max_d = $signed(score_vector[0]);
          run_idx_d = '0;
          cnt_d     = IDX_W'(1);
          if (NUM_CLASSES == 1) begin
            load       = 1'b1;
            load_idx   = '0;
            load_score = $signed(score_vector[0]);
            state_d    = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        run_max_d = cand_max;
        run_idx_d = cand_idx;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          load       = 1'b1;
          load_idx   = cand_idx;
          load_score = cand_max;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      result_valid_d = 1'b1;
    end
    in_ready_d = (state_d == IDLE);
  end

  // FSM state, snapshot buffer and running maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registered result and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      class_idx    <= '0;
      max_score    <= '0;
      result_valid <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      result_valid <= result_valid_d;
      in_ready     <= in_ready_d;
      if (load) begin
        class_idx <= load_idx;
        max_score <= load_score;
      end
    end
  end

`ifdef SCORE_THRESHOLD_EN
  logic no_match_q;

  // Below-threshold flag captured with the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      no_match_q <= 1'b0;
    end else if (load) begin
      no_match_q <= (load_score < THRESHOLD);
    end
  end

  assign no_match = no_match_q;
`else
  assign no_match = 1'b0;
`endif

endmodule

// File: doc/class_argmax.md
Name: class_argmax

Overview:
- Downstream stage of the third dense layer. Classifies its output.
- Snapshots the 32 signed 64-bit scores in one handshake cycle, then scans them sequentially, one compare per cycle.
- Returns the winning class index and its score through a valid/ready result handshake.
- Last stage of the speech-recognition datapath; its result feeds the class/command decoder.

Parameters:
- NUM_CLASSES, default OUT_SIZE_3 (32): number of scores scanned; must be >= 1.
- SCORE_W, default 64: signed score width; matches the dense layer 3 output width.
- IDX_W, default $clog2(NUM_CLASSES) (5), minimum 1: class index width.
- THRESHOLD, default 64'sd0: signed minimum winning score. Used only with SCORE_THRESHOLD_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- score_vector  in  SCORE_W x NUM_CLASSES  signed scores from dense_layer_3. Sampled only on an accepted input.
- in_valid  in  1  score_vector is valid.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- class_idx  out  IDX_W  index of the maximum score.
- max_score  out  SCORE_W  signed maximum score.
- no_match  out  1  winning score below THRESHOLD. Tied 0 without the macro.
- result_valid  out  1  class_idx, max_score and no_match are valid.
- result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready=1 once released.
  - class_idx=0, max_score=0, no_match=0, result_valid=0.
  - Snapshot buffer and scan counter cleared.
  - Reset during SCAN or DONE aborts; the in-flight vector is discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: copy all NUM_CLASSES scores into the buffer; run_max<=buf[0]; run_idx<=0; cnt<=1.
  - Next state: SCAN; if NUM_CLASSES==1, go directly to DONE with outputs loaded.
- SCAN:
  - in_ready=0; in_valid is ignored and score_vector changes have no effect.
  - Each cycle: if buf[cnt] > run_max (signed, strict), update run_max and run_idx. cnt increments.
  - When cnt==NUM_CLASSES-1, the final compare result is loaded directly into class_idx/max_score (and no_match), result_valid<=1, state<=DONE.
- Ties: strict compare, so the lowest index wins.
- Latency: vector accepted at edge k, result_valid high after edge k+NUM_CLASSES-1 (31 cycles for 32 classes). No pipelining: one vector in flight at a time.
- DONE:
  - Outputs held stable while result_valid=1 and result_ready=0.
  - On result_valid && result_ready at an edge: result_valid<=0, state<=IDLE. Output values are retained until the next load.
- Simultaneous events: in_valid in the same cycle as the DONE handshake is not accepted (in_ready=0). It is accepted on the next cycle in IDLE.
- result_ready is ignored outside DONE.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro SCORE_THRESHOLD_EN.
- Defined: at the DONE load, no_match <= (final max < THRESHOLD), signed compare. It is held with the result and reset to 0.
- Undefined: no_match is constant 0 and no compare logic is built. The port list is identical either way.

Decomposition:
- Package nn_parameters gains:
  - CLASS_IDX_W = $clog2(OUT_SIZE_3).
  - SCORE_W_3 = 64.
  - typedef logic signed [SCORE_W_3-1:0] score_t.
  - typedef logic [CLASS_IDX_W-1:0] class_idx_t.
  - CLASS_THRESHOLD constant (default for THRESHOLD).
- Single module. The FSM and scan datapath are too small to justify a sub-module.

Test Plan:
- Reset: hold rst=0 mid-SCAN -> all outputs 0, in_ready=1 after release. A new vector then gives a correct result.
- Ascending scores 0..31, in_valid for 1 cycle -> result_valid exactly 31 cycles later, class_idx=31, max_score=31.
- All scores -5 except [7]=-2 and [20]=-2 -> class_idx=7 (lowest-index tie), max_score=-2. Checks the signed compare.
- result_ready held 0 for 10 cycles in DONE, score_vector and in_valid toggling -> outputs stable, in_ready=0. Handshake on cycle 11 -> IDLE. A back-to-back in_valid is accepted one cycle after the handshake.
- Scores [0]=64'sh7FFF_FFFF_FFFF_FFFF, others negative -> class_idx=0, max_score=max positive. Checks index-0 initialisation and the full-width compare.
- SCORE_THRESHOLD_EN with THRESHOLD=100, max score 99 -> no_match=1; max score 100 -> no_match=0. Without the macro, no_match=0 for both.
